// File: rtl/fc_layer_engine.sv
// fc_layer_engine
//   Computes one fully-connected layer, one multiply-accumulate per cycle.
//   For each output neuron j, the result is
//       bias[j] + sum_i w[j][i] * x[i]
//   in signed fixed point. The result is saturated and optionally passed
//   through ReLU. It is then written to the downstream layer through the
//   load_* strobe.
//
// Ports
//   clk, reset_n            : clock (rising edge), asynchronous active-low reset
//   start                   : begin a layer; only honoured while idle
//   in_values[i]            : input neuron values, held stable while busy
//   weight_addr/weight_data : weight ROM, address j*IN_SZ+i, 1-cycle read latency
//   bias_addr/bias_data     : bias ROM, address j, 1-cycle read latency
//   load_en/value/address   : registered write strobe to the downstream layer
//   busy                    : high whenever not idle
//   done                    : one-cycle pulse after the last neuron is written
module fc_layer_engine #(
    parameter int SIZE   = 16,
    parameter int FRAC   = 8,
    parameter int IN_SZ  = 120,
    parameter int OUT_SZ = 84,
    parameter int RELU   = 1,
    localparam int WA_W  = ($clog2(IN_SZ*OUT_SZ) > 0) ? $clog2(IN_SZ*OUT_SZ) : 1,
    localparam int BA_W  = ($clog2(OUT_SZ) > 0) ? $clog2(OUT_SZ) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [0:IN_SZ-1][SIZE-1:0]  in_values,
    output logic [WA_W-1:0]             weight_addr,
    input  logic [SIZE-1:0]             weight_data,
    output logic [BA_W-1:0]             bias_addr,
    input  logic [SIZE-1:0]             bias_data,
    output logic                        load_en,
    output logic [SIZE-1:0]             load_value,
    output logic [SIZE-1:0]             load_address,
    output logic                        busy,
    output logic                        done
);

    localparam int IW = ($clog2(IN_SZ) > 0) ? $clog2(IN_SZ) : 1;
    // Wide enough that IN_SZ full-scale products plus a shifted bias never overflow.
    localparam int AW = 2*SIZE + $clog2(IN_SZ) + 1;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_BIAS,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [IW-1:0]          i_reg, i_next;
    logic [BA_W-1:0]        j_reg, j_next;
    logic [WA_W-1:0]        base_reg, base_next;   // j*IN_SZ, kept incrementally
    logic signed [AW-1:0]   acc_reg, acc_next;
    logic                   load_en_reg, load_en_next;
    logic [SIZE-1:0]        load_value_reg, load_value_next;
    logic [SIZE-1:0]        load_address_reg, load_address_next;

    // Unpack the input vector so each element can be selected by i.
    logic signed [SIZE-1:0] x_arr [IN_SZ];
    genvar gi;
    generate
        for (gi = 0; gi < IN_SZ; gi++) begin : g_unpack
            assign x_arr[gi] = in_values[gi];
        end
    endgenerate

    // MAC datapath
    logic signed [SIZE-1:0]   x_sel;
    logic signed [2*SIZE-1:0] prod;
    logic signed [AW-1:0]     prod_ext;
    logic signed [AW-1:0]     bias_term;
    logic signed [AW-1:0]     acc_sum;
    logic signed [AW-1:0]     shifted;
    logic [SIZE-1:0]          sat_val;
    logic [SIZE-1:0]          result_val;

    always_comb begin
        x_sel     = x_arr[i_reg];
        prod      = $signed(weight_data) * x_sel;
        prod_ext  = {{(AW-2*SIZE){prod[2*SIZE-1]}}, prod};
        bias_term = {{(AW-SIZE){bias_data[SIZE-1]}}, bias_data};
        bias_term = bias_term <<< FRAC;
        // The bias arrives from ROM exactly when the first product does.
        // So it seeds the accumulator on i==0 instead of taking a cycle of its own.
        acc_sum   = ((i_reg == '0) ? bias_term : acc_reg) + prod_ext;
        shifted   = acc_sum >>> FRAC;
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[SIZE-1:0];
        end else begin
            sat_val = shifted[SIZE-1:0];
        end
        if ((RELU != 0) && sat_val[SIZE-1]) begin
            result_val = '0;
        end else begin
            result_val = sat_val;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next        = state_reg;
        i_next            = i_reg;
        j_next            = j_reg;
        base_next         = base_reg;
        acc_next          = acc_reg;
        load_en_next      = 1'b0;
        load_value_next   = '0;
        load_address_next = '0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    j_next     = '0;
                    base_next  = '0;
                    state_next = S_LOAD_BIAS;
                end
            end
            S_LOAD_BIAS: begin
                i_next     = '0;
                state_next = S_MAC;
            end
            S_MAC: begin
                acc_next = acc_sum;
                if (i_reg == IW'(IN_SZ-1)) begin
                    // Register the finished result so it appears during WRITE.
                    load_en_next      = 1'b1;
                    load_value_next   = result_val;
                    load_address_next = SIZE'(j_reg);
                    state_next        = S_WRITE;
                end else begin
                    i_next = i_reg + IW'(1);
                end
            end
            S_WRITE: begin
                if (j_reg == BA_W'(OUT_SZ-1)) begin
                    state_next = S_DONE;
                end else begin
                    j_next     = j_reg + BA_W'(1);
                    base_next  = base_reg + WA_W'(IN_SZ);
                    state_next = S_LOAD_BIAS;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= S_IDLE;
            i_reg            <= '0;
            j_reg            <= '0;
            base_reg         <= '0;
            acc_reg          <= '0;
            load_en_reg      <= 1'b0;
            load_value_reg   <= '0;
            load_address_reg <= '0;
        end else begin
            state_reg        <= state_next;
            i_reg            <= i_next;
            j_reg            <= j_next;
            base_reg         <= base_next;
            acc_reg          <= acc_next;
            load_en_reg      <= load_en_next;
            load_value_reg   <= load_value_next;
            load_address_reg <= load_address_next;
        end
    end

    // ROM addresses lead the data by one cycle: the MAC for index i presents address i+1.
    always_comb begin
        weight_addr = '0;
        bias_addr   = '0;
        case (state_reg)
            S_LOAD_BIAS: begin
                weight_addr = base_reg;
                bias_addr   = j_reg;
            end
            S_MAC: begin
                weight_addr = base_reg + WA_W'(i_reg) + WA_W'(1);
                bias_addr   = j_reg;
            end
            default: begin
                weight_addr = '0;
                bias_addr   = '0;
            end
        endcase
    end

    assign load_en      = load_en_reg;
    assign load_value   = load_value_reg;
    assign load_address = load_address_reg;
    assign busy         = (state_reg != S_IDLE);
    assign done         = (state_reg == S_DONE);

endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

Sequential fixed-point compute engine for one fully-connected layer. Reads the previous layer's packed neuron values, fetches weights and biases from external synchronous ROMs, and computes each output neuron as bias plus dot product, one multiply-accumulate per cycle. Each finished result is saturated, optionally passed through ReLU, and written into the downstream neuron-layer register through its `load_en`/`load_value`/`load_address` port.

## Interface

**Parameters**

- `SIZE`, 16: word width; signed fixed point, FRAC fractional bits.
- `FRAC`, 8: fractional bits of all values, weights and biases.
- `IN_SZ`, 120: number of input neurons.
- `OUT_SZ`, 84: number of output neurons.
- `RELU`, 1: 1 clamps negative results to 0; 0 passes signed results through.

**Ports** (clock and reset first)

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin layer computation; sampled in IDLE only.
- `in_values` in [0:IN_SZ-1][SIZE-1:0]: input neuron values; caller holds stable while `busy`.
- `weight_addr` out clog2(IN_SZ*OUT_SZ): weight ROM address = j*IN_SZ+i.
- `weight_data` in SIZE: w[j][i]; valid one cycle after its address.
- `bias_addr` out clog2(OUT_SZ): bias ROM address = j.
- `bias_data` in SIZE: b[j]; valid one cycle after its address.
- `load_en` out 1: write strobe to the downstream layer.
- `load_value` out SIZE: result for neuron `load_address`.
- `load_address` out SIZE: output neuron index j, zero-extended.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last write.

## Operation

**States:** IDLE, LOAD_BIAS, MAC, WRITE, DONE.

- **IDLE:** `start`=1 sets j=0 and moves to LOAD_BIAS. `start` in any other state is ignored.
- **LOAD_BIAS:** drives `bias_addr`=j and `weight_addr`=j*IN_SZ. Sets i=0, then moves to MAC.
- **MAC:** one cycle per i, from 0 to IN_SZ-1.
  - Update: acc <= (i==0 ? sext(bias_data)<<FRAC : acc) + sext(weight_data)*sext(in_values[i]).
  - Drives `weight_addr`=j*IN_SZ+i+1.
  - When i==IN_SZ-1, moves to WRITE.
- **WRITE:** `load_en`=1, `load_address`=j, `load_value`=result(acc).
  - If j==OUT_SZ-1, moves to DONE; otherwise j++ and moves to LOAD_BIAS.
- **DONE:** `done`=1 for one cycle, then moves to IDLE.

**Arithmetic**

- Accumulator is signed, 2*SIZE+clog2(IN_SZ)+1 bits wide. It never overflows.
- result = acc >>> FRAC (arithmetic shift, truncation toward -inf).
- The result then saturates to [-2^(SIZE-1), 2^(SIZE-1)-1].
- If RELU=1, negative values become 0 after saturation.

**Outputs**

- `load_en`, `load_value`, `load_address` are driven from registers. They are nonzero only in WRITE and are 0 otherwise.
- `weight_addr`/`bias_addr` outside LOAD_BIAS/MAC are don't-care. They are held at 0.

**Reset**

- Asserting `reset_n` low at any time, including mid-layer, immediately forces IDLE.
- Reset clears acc, i and j. All outputs go to 0.
- A partially computed neuron is never written.
- After reset deasserts, the engine waits for a new `start`.

## Timing

- Cycle 0 is the first cycle after the edge that samples `start`=1 in IDLE. The engine is in LOAD_BIAS during cycle 0.
- Each neuron takes IN_SZ+2 cycles: one LOAD_BIAS, IN_SZ MAC, one WRITE.
- `load_en` for neuron j is high during cycle (j+1)(IN_SZ+2)-1. It is exactly one cycle wide, and there is exactly one per neuron, in ascending j order.
- `done` is high during cycle OUT_SZ*(IN_SZ+2). `busy` is high in cycles 0 through OUT_SZ*(IN_SZ+2).
- `start` held high continuously:
  - A new layer begins on the edge after DONE returns to IDLE.
  - `busy` drops for exactly one cycle.
- ROM latency is fixed at one cycle. The engine has no stall input.

## Test plan

Test configuration: IN_SZ=3, OUT_SZ=2, FRAC=8, SIZE=16.

- **Basic dot product:** x={0x0100,0x0200,0x0300}, w0={0x0100,0x0100,0x0100}, b0=0x0080. Required: `load_en` at cycle 4 with addr 0 and value 0x0680 (6.5).
- **Negative result:** w1={0xFF00,0xFF00,0xFF00}, b1=0. Required with RELU=1: value 0x0000 at cycle 9, addr 1. Required with RELU=0: value 0xFA00.
- **Saturation:** all x, w and b = 0x7FFF. Required: value 0x7FFF. With w=0x8000 and RELU=0, required value is 0x8000.
- **Cycle accounting:**
  - `load_en` exactly in cycles 4 and 9; `done` only in cycle 10; `busy` in cycles 0-10.
  - `weight_addr` sequence 0,1,2,3 then 3,4,5,6 (the trailing value in each MAC run is don't-care).
  - A `start` pulse during cycle 6 has no effect.
- **Reset mid-layer:** pull `reset_n` low during cycle 7.
  - All outputs go to 0 asynchronously.
  - No write for neuron 1 occurs.
  - After release, a new `start` reproduces the cycle-4 write for neuron 0 from scenario 1.
- **Back-to-back:** `start` held high.
  - Second layer cycle 0 occurs 2 cycles after the `done` cycle.
  - The same values are written again.
